// File: rtl/qp_pkg.sv
// Shared WQE field layout, DCS register map and dispatch FSM states for the queue-pair datapath.
package qp_pkg;

    localparam int unsigned WQE_W        = 112;
    localparam int unsigned OPC_W        = 5;
    localparam int unsigned NUM_W        = 3;
    localparam int unsigned LEN_W        = 8;
    localparam int unsigned MAX_DATA     = 4;
    localparam int unsigned LEN_IDX_W    = $clog2(MAX_DATA);
    localparam int unsigned TID_W        = 8;
    localparam int unsigned ADDR_W       = 64;
    localparam int unsigned TOT_W        = 10;
    localparam int unsigned OPC_LSB      = 107;
    localparam int unsigned NUM_MSB      = 106;
    localparam int unsigned NUM_LSB      = 104;
    localparam int unsigned OPC_PATH_BIT = 0;

    localparam int unsigned DCS_AW = 8;
    localparam int unsigned DCS_DW = 32;
    localparam int unsigned DCS_BW = 4;
    localparam int unsigned CRED_W = 4;
    localparam int unsigned STAT_W = 16;

    localparam logic [DCS_AW-1:0] DCS_OFF_ADDR_LO  = 8'h00;
    localparam logic [DCS_AW-1:0] DCS_OFF_ADDR_HI  = 8'h04;
    localparam logic [DCS_AW-1:0] DCS_OFF_CTRL     = 8'h08;
    localparam logic [DCS_AW-1:0] DCS_OFF_DOORBELL = 8'h0C;
    localparam logic [DCS_DW-1:0] DOORBELL_VAL     = 32'h1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_W0,
        ST_W1,
        ST_W2,
        ST_W3
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]               opcode;
        logic [NUM_W-1:0]               data_num;
        logic [MAX_DATA-1:0][LEN_W-1:0] data_len;   // [MAX_DATA-1] is dataLen0
        logic [TID_W-1:0]               tid;
        logic [ADDR_W-1:0]              desc_addr;
    } wqe_t;

    function automatic logic wqe_malformed(input logic [NUM_W-1:0] num);
        return (num == '0) || (num > NUM_W'(MAX_DATA));
    endfunction

    function automatic logic [TOT_W-1:0] wqe_total_len(input wqe_t w);
        logic [TOT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < int'(MAX_DATA); i++) begin
            if (NUM_W'(i) < w.data_num)
                sum = sum + TOT_W'(w.data_len[LEN_IDX_W'(int'(MAX_DATA) - 1 - i)]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/dcs_write_port.sv
// Avalon-MM write master toward one descriptor-control slave; holds a word until the slave accepts it.
module dcs_write_port
    import qp_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [DCS_AW-1:0] addr_in,
    input  logic [DCS_DW-1:0] data_in,
    input  logic              wait_request,
    output logic              chip_select,
    output logic              write,
    output logic              read,
    output logic [DCS_AW-1:0] address,
    output logic [DCS_DW-1:0] write_data,
    output logic [DCS_BW-1:0] byte_enable
);

    assign read = 1'b0;

    // a stalled word is frozen; otherwise load the next word (or zeros when idle)
    always_ff @(posedge clock) begin
        if (!reset) begin
            chip_select <= 1'b0;
            write       <= 1'b0;
            address     <= '0;
            write_data  <= '0;
            byte_enable <= '0;
        end else if (!(chip_select && wait_request)) begin
            chip_select <= req;
            write       <= req;
            address     <= req ? addr_in : '0;
            write_data  <= req ? data_in : '0;
            byte_enable <= req ? {DCS_BW{1'b1}} : '0;
        end
    end

endmodule

// File: rtl/wqe_dispatch.sv
// Pops WQEs and programs the read/write DMA descriptor controllers with a four-word DCS burst.
// Optional statistics counters: define WQE_DISPATCH_STATS_EN.
module wqe_dispatch
    import qp_pkg::*;
#(
    parameter int unsigned       MAX_OUTSTANDING = 4,
    parameter logic [DCS_AW-1:0] DCS_BASE        = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wqEmpty,
    input  logic [WQE_W-1:0]  wqData,
    output logic              wqPop,
    output logic              rdDcsChipSelect_o,
    output logic              rdDcsWrite_o,
    output logic [DCS_AW-1:0] rdDcsAddress_o,
    output logic [DCS_DW-1:0] rdDcsWriteData_o,
    output logic [DCS_BW-1:0] rdDcsByteEnable_o,
    output logic              rdDcsRead_o,
    input  logic              rdDcsWaitRequest_i,
    output logic              wrDcsChipSelect_o,
    output logic              wrDcsWrite_o,
    output logic [DCS_AW-1:0] wrDcsAddress_o,
    output logic [DCS_DW-1:0] wrDcsWriteData_o,
    output logic [DCS_BW-1:0] wrDcsByteEnable_o,
    output logic              wrDcsRead_o,
    input  logic              wrDcsWaitRequest_i,
    input  logic              rdDone,
    input  logic              wrDone,
    output logic              busy,
    output logic [STAT_W-1:0] dropCount,
    output logic [STAT_W-1:0] dispatchCount
);

    state_t            state_q, state_d;
    wqe_t              wqe_q;
    logic [TOT_W-1:0]  total_len_q;
    logic [CRED_W-1:0] rd_credit_q, wr_credit_q;

    logic              pop, doorbell_acc, word_vld;
    logic [DCS_AW-1:0] word_addr;
    logic [DCS_DW-1:0] word_data;

    logic head_wr, head_bad, head_ok, path_wr, wqe_bad, sel_wait;

    assign head_wr  = wqData[OPC_LSB + OPC_PATH_BIT];
    assign head_bad = wqe_malformed(wqData[NUM_MSB:NUM_LSB]);
    assign head_ok  = head_wr ? (wr_credit_q < CRED_W'(MAX_OUTSTANDING))
                              : (rd_credit_q < CRED_W'(MAX_OUTSTANDING));
    assign path_wr  = wqe_q.opcode[OPC_PATH_BIT];
    assign wqe_bad  = wqe_malformed(wqe_q.data_num);
    assign sel_wait = path_wr ? wrDcsWaitRequest_i : rdDcsWaitRequest_i;
    assign wqPop    = pop;
    assign busy     = (state_q != ST_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next state; a malformed head is always popped so it cannot block the queue
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        doorbell_acc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (reset && !wqEmpty && (head_bad || head_ok)) begin
                    pop     = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = wqe_bad ? ST_IDLE : ST_W0;
            ST_W0:     if (!sel_wait) state_d = ST_W1;
            ST_W1:     if (!sel_wait) state_d = ST_W2;
            ST_W2:     if (!sel_wait) state_d = ST_W3;
            ST_W3: begin
                if (!sel_wait) begin
                    doorbell_acc = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // the word driven on the bus follows the state being entered, so strobes are registered
    always_comb begin
        word_vld  = 1'b0;
        word_addr = '0;
        word_data = '0;
        unique case (state_d)
            ST_W0: begin
                word_vld  = 1'b1;
                word_addr = DCS_BASE + DCS_OFF_ADDR_LO;
                word_data = wqe_q.desc_addr[31:0];
            end
            ST_W1: begin
                word_vld  = 1'b1;
                word_addr = DCS_BASE + DCS_OFF_ADDR_HI;
                word_data = wqe_q.desc_addr[63:32];
            end
            ST_W2: begin
                word_vld  = 1'b1;
                word_addr = DCS_BASE + DCS_OFF_CTRL;
                word_data = {wqe_q.tid, 6'b0, total_len_q, 3'b0, wqe_q.opcode};
            end
            ST_W3: begin
                word_vld  = 1'b1;
                word_addr = DCS_BASE + DCS_OFF_DOORBELL;
                word_data = DOORBELL_VAL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wqe_q       <= '0;
            total_len_q <= '0;
        end else begin
            if (pop)                    wqe_q       <= wqe_t'(wqData);
            if (state_q == ST_DECODE)   total_len_q <= wqe_total_len(wqe_q);
        end
    end

    // outstanding transfers per path; a done coinciding with a doorbell cancels out
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_credit_q <= '0;
            wr_credit_q <= '0;
        end else begin
            if (doorbell_acc && !path_wr && !rdDone)        rd_credit_q <= rd_credit_q + CRED_W'(1);
            else if (!(doorbell_acc && !path_wr) && rdDone && rd_credit_q != '0)
                                                            rd_credit_q <= rd_credit_q - CRED_W'(1);
            if (doorbell_acc && path_wr && !wrDone)         wr_credit_q <= wr_credit_q + CRED_W'(1);
            else if (!(doorbell_acc && path_wr) && wrDone && wr_credit_q != '0)
                                                            wr_credit_q <= wr_credit_q - CRED_W'(1);
        end
    end

    dcs_write_port u_rd_port (
        .clock        (clock),
        .reset        (reset),
        .req          (word_vld && !path_wr),
        .addr_in      (word_addr),
        .data_in      (word_data),
        .wait_request (rdDcsWaitRequest_i),
        .chip_select  (rdDcsChipSelect_o),
        .write        (rdDcsWrite_o),
        .read         (rdDcsRead_o),
        .address      (rdDcsAddress_o),
        .write_data   (rdDcsWriteData_o),
        .byte_enable  (rdDcsByteEnable_o)
    );

    dcs_write_port u_wr_port (
        .clock        (clock),
        .reset        (reset),
        .req          (word_vld && path_wr),
        .addr_in      (word_addr),
        .data_in      (word_data),
        .wait_request (wrDcsWaitRequest_i),
        .chip_select  (wrDcsChipSelect_o),
        .write        (wrDcsWrite_o),
        .read         (wrDcsRead_o),
        .address      (wrDcsAddress_o),
        .write_data   (wrDcsWriteData_o),
        .byte_enable  (wrDcsByteEnable_o)
    );

`ifdef WQE_DISPATCH_STATS_EN
    logic [STAT_W-1:0] drop_cnt_q, disp_cnt_q;
    logic              drop_evt;

    assign drop_evt = (state_q == ST_DECODE) && wqe_bad;

    // saturating statistics
    always_ff @(posedge clock) begin
        if (!reset) begin
            drop_cnt_q <= '0;
            disp_cnt_q <= '0;
        end else begin
            if (drop_evt && drop_cnt_q != {STAT_W{1'b1}})     drop_cnt_q <= drop_cnt_q + STAT_W'(1);
            if (doorbell_acc && disp_cnt_q != {STAT_W{1'b1}}) disp_cnt_q <= disp_cnt_q + STAT_W'(1);
        end
    end

    assign dropCount     = drop_cnt_q;
    assign dispatchCount = disp_cnt_q;
`else
    assign dropCount     = '0;
    assign dispatchCount = '0;
`endif

endmodule
